// File: rtl/arm_ctrl_pkg.sv
// Shared encodings and the E-stage control bundle for the ARM core's control path.
package arm_ctrl_pkg;

  // Condition codes, instruction bits [31:28]
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // ALU operation encodings
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_ORR = 4'b1100;
  localparam logic [3:0] ALU_MOV = 4'b1101;
  localparam logic [3:0] ALU_MVN = 4'b1111;

  // Bit positions inside the NZCV nibble
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Control captured at the D/E boundary
  typedef struct packed {
    logic       valid;
    logic [3:0] cond;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       mem_to_reg;
    logic       alu_src;
    logic [3:0] alu_control;
    logic [1:0] flag_w;
  } e_ctrl_t;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-code evaluator: pass=1 when cond holds for nzcv.
module cond_check
  import arm_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  // Decode the condition field against the flag nibble; NV never passes
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_stage.sv
// Execute-stage control register, conditional-execution gating, NZCV register
// and saturating counter of annulled (condition-failed) instructions.
module cond_exec_stage
  import arm_ctrl_pkg::*;
#(
  parameter int         CNT_W     = 16,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_e,
  input  logic             flush_e,
  input  logic             valid_d,
  input  logic [3:0]       cond_d,
  input  logic             pcs_d,
  input  logic             reg_w_d,
  input  logic             mem_w_d,
  input  logic             mem_to_reg_d,
  input  logic             alu_src_d,
  input  logic [3:0]       alu_control_d,
  input  logic [1:0]       flag_w_d,
  input  logic [3:0]       alu_flags_e,
  output logic             pcs_e,
  output logic             reg_w_e,
  output logic             mem_w_e,
  output logic             mem_to_reg_e,
  output logic             alu_src_e,
  output logic [3:0]       alu_control_e,
  output logic             cond_ex_e,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] annul_count
);

  e_ctrl_t          e_d, e_q;
  logic [3:0]       flags_d, flags_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             cond_pass;

  // Next E-register contents: flush beats stall, stall beats capture
  always_comb begin
    e_d = e_q;
    if (flush_e) begin
      e_d      = '0;
      e_d.cond = COND_AL;
    end else if (!stall_e) begin
      e_d.valid       = valid_d;
      e_d.cond        = cond_d;
      e_d.pcs         = pcs_d;
      e_d.reg_w       = reg_w_d;
      e_d.mem_w       = mem_w_d;
      e_d.mem_to_reg  = mem_to_reg_d;
      e_d.alu_src     = alu_src_d;
      e_d.alu_control = alu_control_d;
      e_d.flag_w      = flag_w_d;
    end
  end

  // Condition is judged only against the architectural flag register
  cond_check u_cond_check (
    .cond (e_q.cond),
    .nzcv (flags_q),
    .pass (cond_pass)
  );

  assign cond_ex_e = e_q.valid & cond_pass;

  // Flag writes by the instruction in E; a flush does not cancel it, a stall does
  always_comb begin
    flags_d = flags_q;
    if (!stall_e && cond_ex_e) begin
      if (e_q.flag_w[1]) begin
        flags_d[FLAG_N] = alu_flags_e[FLAG_N];
        flags_d[FLAG_Z] = alu_flags_e[FLAG_Z];
      end
      if (e_q.flag_w[0]) begin
        flags_d[FLAG_C] = alu_flags_e[FLAG_C];
        flags_d[FLAG_V] = alu_flags_e[FLAG_V];
      end
    end
  end

  // Count valid instructions whose condition failed, sticking at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (!stall_e && e_q.valid && !cond_pass && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  // State registers; reset clears everything so gated outputs drop immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q     <= '0;
      flags_q <= FLAGS_RST;
      cnt_q   <= '0;
    end else begin
      e_q     <= e_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pcs_e         = e_q.pcs   & cond_ex_e;
  assign reg_w_e       = e_q.reg_w & cond_ex_e;
  assign mem_w_e       = e_q.mem_w & cond_ex_e;
  assign mem_to_reg_e  = e_q.mem_to_reg;
  assign alu_src_e     = e_q.alu_src;
  assign alu_control_e = e_q.alu_control;
  assign flags         = flags_q;
  assign annul_count   = cnt_q;

endmodule

// File: tb/tb_cond_exec_stage.sv
// Directed bench for cond_exec_stage; a second instance with CNT_W=4 covers saturation.
module tb_cond_exec_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_e, flush_e, valid_d;
  logic [3:0]  cond_d;
  logic        pcs_d, reg_w_d, mem_w_d, mem_to_reg_d, alu_src_d;
  logic [3:0]  alu_control_d;
  logic [1:0]  flag_w_d;
  logic [3:0]  alu_flags_e;

  logic        pcs_e, reg_w_e, mem_w_e, mem_to_reg_e, alu_src_e, cond_ex_e;
  logic [3:0]  alu_control_e, flags;
  logic [15:0] annul_count;

  logic        s_pcs_e, s_reg_w_e, s_mem_w_e, s_mem_to_reg_e, s_alu_src_e, s_cond_ex_e;
  logic [3:0]  s_alu_control_e, s_flags;
  logic [3:0]  s_annul_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cond_exec_stage #(.CNT_W(16), .FLAGS_RST(4'b0000)) dut (
    .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
    .valid_d(valid_d), .cond_d(cond_d), .pcs_d(pcs_d), .reg_w_d(reg_w_d),
    .mem_w_d(mem_w_d), .mem_to_reg_d(mem_to_reg_d), .alu_src_d(alu_src_d),
    .alu_control_d(alu_control_d), .flag_w_d(flag_w_d), .alu_flags_e(alu_flags_e),
    .pcs_e(pcs_e), .reg_w_e(reg_w_e), .mem_w_e(mem_w_e), .mem_to_reg_e(mem_to_reg_e),
    .alu_src_e(alu_src_e), .alu_control_e(alu_control_e), .cond_ex_e(cond_ex_e),
    .flags(flags), .annul_count(annul_count)
  );

  cond_exec_stage #(.CNT_W(4), .FLAGS_RST(4'b0000)) dut_sat (
    .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
    .valid_d(valid_d), .cond_d(cond_d), .pcs_d(pcs_d), .reg_w_d(reg_w_d),
    .mem_w_d(mem_w_d), .mem_to_reg_d(mem_to_reg_d), .alu_src_d(alu_src_d),
    .alu_control_d(alu_control_d), .flag_w_d(flag_w_d), .alu_flags_e(alu_flags_e),
    .pcs_e(s_pcs_e), .reg_w_e(s_reg_w_e), .mem_w_e(s_mem_w_e), .mem_to_reg_e(s_mem_to_reg_e),
    .alu_src_e(s_alu_src_e), .alu_control_e(s_alu_control_e), .cond_ex_e(s_cond_ex_e),
    .flags(s_flags), .annul_count(s_annul_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_d();
    valid_d = 0; cond_d = 4'b1110; pcs_d = 0; reg_w_d = 0; mem_w_d = 0;
    mem_to_reg_d = 0; alu_src_d = 0; alu_control_d = 4'b0000; flag_w_d = 2'b00;
  endtask

  task automatic instr(input logic [3:0] c, input logic pcs, input logic rw, input logic mw,
                       input logic [3:0] ctl, input logic [1:0] fw);
    valid_d = 1; cond_d = c; pcs_d = pcs; reg_w_d = rw; mem_w_d = mw;
    mem_to_reg_d = 0; alu_src_d = 0; alu_control_d = ctl; flag_w_d = fw;
  endtask

  logic [15:0] exp_tab;

  initial begin
    reset = 1; stall_e = 0; flush_e = 0; alu_flags_e = 4'b0000;
    idle_d();
    step(); step();
    check("rst_flags", {28'd0, flags}, 32'h0);
    check("rst_count", {16'd0, annul_count}, 32'h0);
    check("rst_cond_ex", {31'd0, cond_ex_e}, 32'h0);
    reset = 0;

    // ADDS: AL, flag_w=11, ADD, reg_w
    instr(4'b1110, 0, 1, 0, 4'b0100, 2'b11);
    alu_flags_e = 4'b0110;
    step();
    check("adds_reg_w", {31'd0, reg_w_e}, 32'h1);
    check("adds_alu_ctl", {28'd0, alu_control_e}, 32'h4);
    check("adds_flags_c1", {28'd0, flags}, 32'h0);
    idle_d();
    step();
    check("adds_flags_c2", {28'd0, flags}, 32'h6);
    check("bubble_reg_w", {31'd0, reg_w_e}, 32'h0);

    // Clear flags so Z=0
    instr(4'b1110, 0, 0, 0, 4'b1101, 2'b11);
    alu_flags_e = 4'b0000;
    step(); idle_d(); step();
    check("clr_flags", {28'd0, flags}, 32'h0);

    // STR EQ with Z=0 -> annulled
    instr(4'b0000, 0, 0, 1, 4'b0100, 2'b00);
    step();
    check("streq_fail_mem_w", {31'd0, mem_w_e}, 32'h0);
    check("streq_fail_cond_ex", {31'd0, cond_ex_e}, 32'h0);
    check("streq_fail_cnt0", {16'd0, annul_count}, 32'h0);
    idle_d();
    step();
    check("streq_fail_cnt1", {16'd0, annul_count}, 32'h1);

    // Set Z=1 with a N,Z-only write, then STR EQ passes
    instr(4'b1110, 0, 0, 0, 4'b0100, 2'b10);
    alu_flags_e = 4'b0100;
    step(); idle_d(); step();
    check("setz_flags", {28'd0, flags}, 32'h4);
    instr(4'b0000, 0, 0, 1, 4'b0100, 2'b00);
    step();
    check("streq_pass_mem_w", {31'd0, mem_w_e}, 32'h1);
    check("streq_pass_cond_ex", {31'd0, cond_ex_e}, 32'h1);
    idle_d();
    step();
    check("streq_pass_cnt", {16'd0, annul_count}, 32'h1);

    // Partial flag writes: 1111, then N,Z<-00 gives 0011, then C,V<-00 gives 0000
    instr(4'b1110, 0, 0, 0, 4'b0100, 2'b11);
    step();
    alu_flags_e = 4'b1111;
    instr(4'b1110, 0, 0, 0, 4'b0100, 2'b10);
    step();
    check("pw_all", {28'd0, flags}, 32'hF);
    alu_flags_e = 4'b0000;
    instr(4'b1110, 0, 0, 0, 4'b0100, 2'b01);
    step();
    check("pw_nz", {28'd0, flags}, 32'h3);
    idle_d();
    step();
    check("pw_cv", {28'd0, flags}, 32'h0);

    // Stall: failing EQ (Z=0) MOV held for 3 cycles, count and flags frozen
    valid_d = 1; cond_d = 4'b0000; pcs_d = 1; reg_w_d = 1; mem_w_d = 0;
    mem_to_reg_d = 1; alu_src_d = 1; alu_control_d = 4'b1101; flag_w_d = 2'b11;
    alu_flags_e = 4'b1111;
    step();
    check("stall_pre_cnt", {16'd0, annul_count}, 32'h1);
    stall_e = 1;
    instr(4'b1110, 0, 1, 0, 4'b0100, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_alu_ctl", {28'd0, alu_control_e}, 32'hD);
      check("stall_mem_to_reg", {31'd0, mem_to_reg_e}, 32'h1);
      check("stall_alu_src", {31'd0, alu_src_e}, 32'h1);
      check("stall_cnt", {16'd0, annul_count}, 32'h1);
      check("stall_flags", {28'd0, flags}, 32'h0);
    end
    stall_e = 0;
    step();
    check("unstall_cnt", {16'd0, annul_count}, 32'h2);
    check("unstall_alu_ctl", {28'd0, alu_control_e}, 32'h4);
    check("unstall_reg_w", {31'd0, reg_w_e}, 32'h1);

    // Stall and flush together -> bubble, no count
    stall_e = 1; flush_e = 1;
    step();
    check("sf_cond_ex", {31'd0, cond_ex_e}, 32'h0);
    check("sf_reg_w", {31'd0, reg_w_e}, 32'h0);
    check("sf_alu_ctl", {28'd0, alu_control_e}, 32'h0);
    stall_e = 0; flush_e = 0;
    idle_d();
    step();
    check("sf_cnt", {16'd0, annul_count}, 32'h2);

    // Flush does not block the flag write of the instruction already in E
    instr(4'b1110, 0, 1, 0, 4'b0100, 2'b11);
    alu_flags_e = 4'b1010;
    step();
    flush_e = 1;
    step();
    flush_e = 0;
    check("flush_flags", {28'd0, flags}, 32'hA);
    check("flush_cond_ex", {31'd0, cond_ex_e}, 32'h0);

    // Reset asserted between edges while reg_w_e=1 and flags=1010
    instr(4'b1110, 1, 1, 1, 4'b0100, 2'b00);
    step();
    check("pre_rst_reg_w", {31'd0, reg_w_e}, 32'h1);
    #2 reset = 1;
    #1;
    check("arst_reg_w", {31'd0, reg_w_e}, 32'h0);
    check("arst_pcs", {31'd0, pcs_e}, 32'h0);
    check("arst_mem_w", {31'd0, mem_w_e}, 32'h0);
    check("arst_flags", {28'd0, flags}, 32'h0);
    check("arst_cnt", {16'd0, annul_count}, 32'h0);
    idle_d();
    step();
    reset = 0;

    // Saturation: 20 failing EQ instructions (flags 0000)
    instr(4'b0000, 0, 1, 0, 4'b0100, 2'b00);
    for (int i = 0; i < 20; i++) step();
    idle_d();
    step();
    check("sat_cnt4", {28'd0, s_annul_count}, 32'hF);
    check("sat_cnt16", {16'd0, annul_count}, 32'd20);

    // Condition sweep against NZCV=0100
    instr(4'b1110, 0, 0, 0, 4'b0100, 2'b11);
    alu_flags_e = 4'b0100;
    step(); idle_d(); step();
    check("sweep_a_flags", {28'd0, flags}, 32'h4);
    exp_tab = 16'b0110_0110_1010_1001;
    for (int c = 0; c < 16; c++) begin
      instr(c[3:0], 0, 0, 0, 4'b0100, 2'b00);
      step();
      check($sformatf("sweep_0100_c%0d", c), {31'd0, cond_ex_e}, {31'd0, exp_tab[c]});
    end

    // Condition sweep against NZCV=1001
    instr(4'b1110, 0, 0, 0, 4'b0100, 2'b11);
    alu_flags_e = 4'b1001;
    step(); idle_d(); step();
    check("sweep_b_flags", {28'd0, flags}, 32'h9);
    exp_tab = 16'b0101_0110_0101_1010;
    for (int c = 0; c < 16; c++) begin
      instr(c[3:0], 0, 0, 0, 4'b0100, 2'b00);
      step();
      check($sformatf("sweep_1001_c%0d", c), {31'd0, cond_ex_e}, {31'd0, exp_tab[c]});
    end
    idle_d();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_exec_stage.md
Name: cond_exec_stage

Overview:
- Execute-stage control register plus conditional-execution unit for the pipelined ARM core.
- Captures the instruction decoder's control outputs and the instruction's condition field at the D/E boundary.
- Evaluates the condition against the architectural NZCV register and gates all architectural side effects: PC write, register write, memory write and flag write.
- Owns the NZCV register and a saturating counter of condition-failed (annulled) instructions.

Parameters:
CNT_W, 16, width of the annulled-instruction counter
FLAGS_RST, 4'b0000, reset value of the NZCV register

Ports:
clk  in  1  core clock
reset  in  1  asynchronous active-high reset
stall_e  in  1  hold the E-stage register and suppress flag update
flush_e  in  1  load a bubble into the E-stage register
valid_d  in  1  D-stage slot holds a real instruction
cond_d  in  4  instruction bits [31:28]
pcs_d  in  1  decoder PC-write request
reg_w_d  in  1  decoder register-write request
mem_w_d  in  1  decoder memory-write request
mem_to_reg_d  in  1  decoder result select
alu_src_d  in  1  decoder ALU operand-B select
alu_control_d  in  4  decoder ALU op (0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1101 MOV, 1111 MVN)
flag_w_d  in  2  [1] update N,Z; [0] update C,V
alu_flags_e  in  4  NZCV produced by the ALU this cycle
pcs_e  out  1  gated PC write
reg_w_e  out  1  gated register write
mem_w_e  out  1  gated memory write
mem_to_reg_e  out  1  registered passthrough
alu_src_e  out  1  registered passthrough
alu_control_e  out  4  registered passthrough
cond_ex_e  out  1  condition passed and slot valid
flags  out  4  current NZCV (N=bit3); C feeds the ALU carry-in
annul_count  out  CNT_W  saturating count of condition-failed valid instructions

Behaviour:
- Reset (asynchronous, active-high):
  - E register cleared to all zeros, including valid_e and cond_e.
  - flags = FLAGS_RST; annul_count = 0.
  - All gated outputs are therefore 0 immediately on reset assertion, without waiting for a clock edge.
- E register update on posedge clk, in priority order:
  - flush_e: load a bubble (all control 0, valid_e=0, cond_e=1110).
  - stall_e: hold all E-register fields.
  - otherwise: capture all *_d inputs and valid_d.
  - flush_e wins over stall_e when both are high.
- Condition evaluation is combinational on cond_e and the flags register (not alu_flags_e):
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1
  - 1111 is reserved and evaluates to 0.
- cond_ex_e = valid_e & condition result.
- Gated outputs: pcs_e, reg_w_e, mem_w_e = the registered request AND cond_ex_e.
- Passthrough outputs: mem_to_reg_e, alu_src_e, alu_control_e are ungated registered values.
- Flag update on posedge, when !stall_e and cond_ex_e:
  - flag_w_e[1] loads N,Z from alu_flags_e.
  - flag_w_e[0] loads C,V from alu_flags_e.
  - Each half updates independently; unselected bits hold.
- Flags and the E register:
  - A flush in the same cycle does not block a flag write by the instruction currently in E; it is already executing.
  - The next E instruction sees the new flags one cycle later. No forwarding: the register is the only source.
- Annul counter: increments on posedge when !stall_e, valid_e=1 and the condition fails.
  - Saturates at all-ones and never wraps.
  - Bubbles are never counted.
- Latency: D inputs appear on the E outputs 1 cycle later; flags written by instruction k are visible to instruction k+1.

Decomposition:
- Shared package arm_ctrl_pkg holds:
  - condition-code constants COND_EQ..COND_AL and COND_NV;
  - ALU_ADD/SUB/AND/ORR/MOV/MVN encodings;
  - the flag bit indices N=3, Z=2, C=1, V=0;
  - a typedef for the E-stage control bundle.
- One sub-module, cond_check: purely combinational (cond[3:0], nzcv[3:0]) -> pass.
  - Instantiated once.
  - Unit-testable exhaustively over its 256 input combinations.

Test Plan:
- Reset mid-operation: with reg_w_e=1 and flags=1010, assert reset between clock edges -> reg_w_e, pcs_e and mem_w_e drop to 0 asynchronously; flags=0000 and annul_count=0 before the next edge.
- ADDS capture: cond_d=1110, flag_w_d=11, alu_control_d=0100, reg_w_d=1, then alu_flags_e=0110 -> after 1 cycle reg_w_e=1; after 2 cycles flags=0110.
- Condition fail: flags Z=0 and a STR with cond_d=0000 (EQ), mem_w_d=1 -> mem_w_e=0, cond_ex_e=0, annul_count increments 0->1; with Z=1 the same instruction gives mem_w_e=1 and the count is unchanged.
- Partial flag write: flags=1111, flag_w_e=10, alu_flags_e=0000 -> flags=0011; then flag_w_e=01 with alu_flags_e=0000 -> flags=0000.
- Stall and flush interaction:
  - stall_e=1 for 3 cycles -> E outputs held, flags and count frozen.
  - stall_e=1 with flush_e=1 -> bubble loaded, cond_ex_e=0, no count.
- Sweep and saturation:
  - all 16 cond values against NZCV=0100 and 1001 -> cond_ex_e matches the table, and cond 1111 gives 0;
  - CNT_W=4 with 20 consecutive failed instructions -> annul_count holds at 15.
